mem_arbiter: RTL and testbench

//  Shares one single-ported, multi-cycle backing memory between the fetch stage (I port)
//  and the memory stage (D port) of the 5-stage pipeline. Grants one port at a time and

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/arb_rr2.sv | 19 +
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM state encoding and grant identifiers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IBUSY = 3'd1,
        ST_DBUSY = 3'd2,
        ST_IRESP = 3'd3,
        ST_DRESP = 3'd4
    } arb_state_e;

    // Encoding of the round-robin history bit.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between fetch (I) and data (D) requesters.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the grant while it is able to issue.
// Ports: req_i/req_d requests, last = port granted most recently, gnt_i/gnt_d one-hot grant.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt_i,
    output logic gnt_d
);

    // On a tie the port that did not win last time gets the grant.
    assign gnt_d = req_d & (~req_i | (last == GRANT_I));
    assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle single-ported memory between the fetch (I) and memory (D) stages.
// Latency: request in cycle 0, earliest mem_ready in cycle 1, stall drops in cycle 2 (3 cycles per access).
// Backpressure: per-port stall held high until the owner's RESP cycle; backend request held until mem_ready.
// Ports: i_* fetch port, d_* data port, mem_* backend port, clk / reset (sync, active-high).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          gnt_i, gnt_d;

    arb_rr2 u_rr (
        .req_i (i_req),
        .req_d (d_req),
        .last  (last_q),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    state_d     = ST_DBUSY;
                    last_d      = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (gnt_i) begin
                    // Fetch is read-only; write data register is left as is.
                    state_d    = ST_IBUSY;
                    last_d     = GRANT_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                end
            end
            ST_IBUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    // A fetch killed while in flight completes silently with no RESP cycle.
                    if (i_req) begin
                        state_d   = ST_IRESP;
                        i_rdata_d = mem_rdata;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DBUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (d_req) begin
                        state_d = ST_DRESP;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            // RESP lasts exactly one cycle and never issues a new grant.
            ST_IRESP: state_d = ST_IDLE;
            ST_DRESP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= GRANT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_stall   = i_req & (state_q != ST_IRESP);
    assign d_stall   = d_req & (state_q != ST_DRESP);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboarded backend model and per-port response monitor.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: requesters hold their request until their stall drops.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;   // mem_ready asserted in the lat-th cycle mem_req is high
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_stall, d_stall;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          checks = 0;
    int          errors = 0;
    int          be_cnt = 0;
    bit          stray_ready = 1'b0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_txn_t txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                     input logic [31:0] rd, input int lat);
        mem_txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd; t.lat = lat;
        return t;
    endfunction

    // Backend model: checks every busy cycle against the head transaction, answers after its latency.
    always @(negedge clk) begin
        mem_txn_t h;
        mem_ready = 1'b0;
        mem_rdata = $urandom();
        if (mem_req) begin
            be_cnt++;
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got addr %h we %b, expected no request", mem_addr, mem_we);
            end else begin
                h = exp_mem[0];
                if (mem_we !== h.we || mem_addr !== h.addr || (h.we && mem_wdata !== h.wdata)) begin
                    errors++;
                    $display("FAIL mem_txn: got we %b addr %h wdata %h, expected we %b addr %h wdata %h",
                             mem_we, mem_addr, mem_wdata, h.we, h.addr, h.wdata);
                end
                if (be_cnt == h.lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = h.rdata;
                    void'(exp_mem.pop_front());
                end
            end
        end else begin
            be_cnt = 0;
        end
        if (stray_ready) begin
            mem_ready   = 1'b1;
            mem_rdata   = 32'hFEEDFACE;
            stray_ready = 1'b0;
        end
    end

    // Response monitor: every completed handshake pops and compares the port's expected data.
    always @(negedge clk) begin
        if (!reset && i_req && !i_stall) begin
            if (exp_i.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_unexpected: got handshake with i_rdata %h, expected none", i_rdata);
            end else begin
                chk("i_rdata", i_rdata, exp_i.pop_front());
            end
        end
        if (!reset && d_req && !d_stall) begin
            if (exp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected: got handshake with d_rdata %h, expected none", d_rdata);
            end else begin
                chk("d_rdata", d_rdata, exp_d.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_i = '0;
        last_d = '0;
    endtask

    task automatic i_access(input logic [31:0] a, input logic [31:0] rd, input int exp_stall, input bit keep);
        int n = 0;
        exp_i.push_back(rd);
        last_i = rd;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = a;
        @(negedge clk);
        while (i_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("i_stall_cycles", n, exp_stall);
        if (!keep) begin
            @(posedge clk); #1 i_req = 1'b0;
        end
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int exp_stall, input bit keep);
        int n = 0;
        if (!we) last_d = rd;
        exp_d.push_back(last_d);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        @(negedge clk);
        while (d_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("d_stall_cycles", n, exp_stall);
        if (!keep) begin
            @(posedge clk); #1 d_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_rdata",   i_rdata, 32'd0);
        chk("rst_d_rdata",   d_rdata, 32'd0);
        #1 reset = 1'b0;

        // 1: single fetch, ready in second busy cycle -> 3 stalled cycles.
        exp_mem.push_back(txn(1'b0, 32'h0040, 32'h0, 32'h20080005, 2));
        i_access(32'h0040, 32'h20080005, 3, 1'b0);

        // 2: simultaneous requests after reset, D wins the first tie.
        do_reset();
        exp_mem.push_back(txn(1'b1, 32'h0100, 32'hDEADBEEF, 32'h0, 1));
        exp_mem.push_back(txn(1'b0, 32'h0044, 32'h0, 32'hA1A2A3A4, 1));
        fork
            d_access(1'b1, 32'h0100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
            i_access(32'h0044, 32'hA1A2A3A4, 5, 1'b0);
        join

        // 3: continuous traffic on both ports alternates D,I,D,I.
        exp_mem.push_back(txn(1'b0, 32'h0500, 32'h0, 32'h11111111, 1));
        exp_mem.push_back(txn(1'b0, 32'h0048, 32'h0, 32'h22222222, 1));
        exp_mem.push_back(txn(1'b1, 32'h0504, 32'h33333333, 32'h0, 1));
        exp_mem.push_back(txn(1'b0, 32'h004C, 32'h0, 32'h44444444, 1));
        fork
            begin
                d_access(1'b0, 32'h0500, 32'h0, 32'h11111111, 2, 1'b1);
                d_access(1'b1, 32'h0504, 32'h33333333, 32'h0, 5, 1'b0);
            end
            begin
                i_access(32'h0048, 32'h22222222, 5, 1'b1);
                i_access(32'h004C, 32'h44444444, 5, 1'b0);
            end
        join

        // 4: fetch killed while busy; backend completes, no RESP, D follows straight from IDLE.
        exp_mem.push_back(txn(1'b0, 32'h0080, 32'h0, 32'h55AA55AA, 3));
        exp_mem.push_back(txn(1'b0, 32'h0300, 32'h0, 32'hCAFEF00D, 1));
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0080;
        @(posedge clk); #1;
        i_req = 1'b0;
        d_access(1'b0, 32'h0300, 32'h0, 32'hCAFEF00D, 4, 1'b0);
        chk("i_rdata_kept", i_rdata, last_i);

        // 6: requester address changes while busy are ignored.
        exp_mem.push_back(txn(1'b0, 32'h0200, 32'h0, 32'h12345678, 3));
        fork
            d_access(1'b0, 32'h0200, 32'h0, 32'h12345678, 4, 1'b0);
            begin
                @(posedge clk); @(posedge clk);
                #2 d_addr = 32'hFFFF0BAD;
                @(posedge clk);
                #2 d_addr = 32'h00000204;
            end
        join

        // 5: reset during DBUSY, then a stray mem_ready.
        do_reset();
        exp_mem.push_back(txn(1'b0, 32'h0400, 32'h0, 32'h0BAD0BAD, 20));
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0400;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_busy_mem_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0; stray_ready = 1'b1;
        void'(exp_mem.pop_front());
        @(negedge clk);
        chk("t5_mem_req_dropped", {31'd0, mem_req}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_d_rdata", d_rdata, 32'd0);
        chk("t5_mem_req_idle", {31'd0, mem_req}, 32'd0);

        repeat (2) @(negedge clk);
        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        chk("exp_i_drained", exp_i.size(), 32'd0);
        chk("exp_d_drained", exp_d.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
